// File: rtl/led_sequence_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : led_sequence_ctrl_if
// Description : Command channel for the LED sequencer. One-word commands
//               move from the host to the sequencer over a valid/ready
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_sequence_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_mode;
    logic [1:0] cmd_speed;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_mode,
        output cmd_speed,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_mode,
        input  cmd_speed,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/led_sequence_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_sequence_ctrl
// Description : Command-driven 8-bit LED chaser. Holds the step prescaler,
//               the pattern register and an IDLE/LOAD/RUN/PAUSE controller.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequence_ctrl #(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
    input  wire logic           clk,
    input  wire logic           reset,
    led_sequence_ctrl_if.slave  cmd,
    output logic [7:0]          led_out,
    output logic                step,
    output logic [7:0]          step_count,
    output logic                running
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_PAUSE = 2'd3;

    localparam logic [1:0] c_OP_START  = 2'd0;
    localparam logic [1:0] c_OP_PAUSE  = 2'd1;
    localparam logic [1:0] c_OP_RESUME = 2'd2;
    localparam logic [1:0] c_OP_STOP   = 2'd3;

    localparam logic [1:0] c_MODE_BLINK = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [1:0]  r_mode;
    logic [1:0]  r_speed;
    logic        r_dir;
    logic [23:0] r_presc;
    logic [7:0]  r_led;
    logic        r_step;
    logic [7:0]  r_step_count;

    logic        w_accept;
    logic        w_start;
    logic        w_stop;
    logic        w_pause;
    logic        w_resume;
    logic        w_advance;
    logic        w_step_due;
    logic [23:0] w_shifted;
    logic [23:0] w_limit;
    logic [7:0]  w_seed;
    logic [7:0]  w_next_led;
    logic        w_next_dir;

    // Handshake decode; cmd_ready itself comes only from the state register.
    assign w_accept = cmd.cmd_valid && cmd.cmd_ready;
    assign w_start  = w_accept && (cmd.cmd_op == c_OP_START);
    assign w_stop   = w_accept && (cmd.cmd_op == c_OP_STOP);
    assign w_pause  = w_accept && (cmd.cmd_op == c_OP_PAUSE)  && (r_state == c_ST_RUN);
    assign w_resume = w_accept && (cmd.cmd_op == c_OP_RESUME) && (r_state == c_ST_PAUSE);

    // Step period; speeds that shift the count to zero are clamped to one cycle.
    assign w_shifted  = TICK_COUNT >> r_speed;
    assign w_limit    = (w_shifted == 24'd0) ? 24'd1 : w_shifted;
    assign w_step_due = (r_presc == (w_limit - 24'd1));

    // A RUN cycle advances the pattern timer unless a command takes over the edge.
    assign w_advance = (r_state == c_ST_RUN) && !w_start && !w_stop && !w_pause;

    assign w_seed = (r_mode == c_MODE_BLINK) ? 8'h00 : 8'hFE;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: an accepted command beats the LOAD->RUN hand-off.
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = c_ST_LOAD;
        end else if (w_stop) begin
            w_next_state = c_ST_IDLE;
        end else if (w_pause) begin
            w_next_state = c_ST_PAUSE;
        end else if (w_resume) begin
            w_next_state = c_ST_RUN;
        end else if (r_state == c_ST_LOAD) begin
            w_next_state = c_ST_RUN;
        end
    end

    // State-decoded outputs.
    always_comb begin
        cmd.cmd_ready = (r_state != c_ST_LOAD);
        running       = (r_state == c_ST_RUN);
    end

    // Next pattern and bounce direction for the currently latched mode.
    always_comb begin
        w_next_led = r_led;
        w_next_dir = r_dir;
        case (r_mode)
            2'd0: w_next_led = {r_led[6:0], r_led[7]};
            2'd1: w_next_led = {r_led[0], r_led[7:1]};
            2'd2: begin
                if (!r_dir && !r_led[7]) begin
                    w_next_dir = 1'b1;
                    w_next_led = {r_led[0], r_led[7:1]};
                end else if (r_dir && !r_led[0]) begin
                    w_next_dir = 1'b0;
                    w_next_led = {r_led[6:0], r_led[7]};
                end else if (r_dir) begin
                    w_next_led = {r_led[0], r_led[7:1]};
                end else begin
                    w_next_led = {r_led[6:0], r_led[7]};
                end
            end
            default: w_next_led = ~r_led;
        endcase
    end

    // Datapath: command side effects, seeding, prescaler and pattern stepping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode       <= 2'd0;
            r_speed      <= 2'd0;
            r_dir        <= 1'b0;
            r_presc      <= 24'd0;
            r_led        <= 8'h00;
            r_step       <= 1'b0;
            r_step_count <= 8'd0;
        end else begin
            r_step <= 1'b0;
            if (w_start) begin
                r_mode       <= cmd.cmd_mode;
                r_speed      <= cmd.cmd_speed;
                r_presc      <= 24'd0;
                r_step_count <= 8'd0;
            end else if (w_stop) begin
                r_led   <= 8'h00;
                r_presc <= 24'd0;
            end else if (r_state == c_ST_LOAD) begin
                r_led <= w_seed;
                r_dir <= 1'b0;
            end else if (w_advance) begin
                if (w_step_due) begin
                    r_presc      <= 24'd0;
                    r_led        <= w_next_led;
                    r_dir        <= w_next_dir;
                    r_step       <= 1'b1;
                    r_step_count <= r_step_count + 8'd1;
                end else begin
                    r_presc <= r_presc + 24'd1;
                end
            end
        end
    end

    assign led_out    = r_led;
    assign step       = r_step;
    assign step_count = r_step_count;

endmodule
`default_nettype wire
